// File: rtl/a2d_spi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : a2d_pkg
// Brief    : Shared types, widths and helpers for the A2D SPI bridge.
// Revision : 1.0 - initial release
// ============================================================================
package a2d_pkg;

    localparam int FRAME_W = 16;
    localparam int RES_W   = 12;
    localparam int CH_W    = 3;

    // Divider encodings for the default 5-bit divider (SCLK period 32 clk)
    localparam logic [4:0] DIV_LOAD = 5'b10111;
    localparam logic [4:0] DIV_FALL = 5'b11111;
    localparam logic [4:0] DIV_RISE = 5'b01111;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE = 3'd0;
    localparam state_t c_ST_FRM1 = 3'd1;
    localparam state_t c_ST_GAP  = 3'd2;
    localparam state_t c_ST_FRM2 = 3'd3;
    localparam state_t c_ST_DONE = 3'd4;

    // Channel-select command: channel sits in bits [13:11], all else zero
    function automatic logic [FRAME_W-1:0] build_cmd(input logic [CH_W-1:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/a2d_spi_bridge_spi_frame16.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame16
// Brief    : One 16-bit SPI mode-3 transaction. SCLK idles high, MOSI
//            changes on falling edges, MISO is sampled on rising edges.
//            done is a single-cycle strobe on the clk that ends the frame;
//            rx_data is the complete received word during that strobe.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame16
    import a2d_pkg::*;
#(
    parameter int DIV_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [FRAME_W-1:0] cmd,
    input  logic               MISO,
    output logic               done,
    output logic [FRAME_W-1:0] rx_data,
    output logic               SCLK,
    output logic               MOSI,
    output logic               ss_req
);

    logic [DIV_W-1:0]   w_div_load;
    logic [DIV_W-1:0]   w_div_fall;
    logic [DIV_W-1:0]   w_div_rise;

    logic [DIV_W-1:0]   r_div;
    logic [FRAME_W-1:0] r_shift;
    logic               r_smp;
    logic               r_active;
    logic [4:0]         r_bit_cnt;

    logic               w_fall;
    logic               w_rise;
    logic               w_last;

    // The preset sits 9 counts below wrap, which sets the SS_n-to-first-fall porch
    generate
        if (DIV_W == 5) begin : g_div_pkg
            assign w_div_load = DIV_LOAD;
            assign w_div_fall = DIV_FALL;
            assign w_div_rise = DIV_RISE;
        end else begin : g_div_gen
            assign w_div_fall = {DIV_W{1'b1}};
            assign w_div_rise = {1'b0, {(DIV_W-1){1'b1}}};
            assign w_div_load = {DIV_W{1'b1}} - DIV_W'(8);
        end
    endgenerate

    assign w_fall  = r_active && (r_div == w_div_fall);
    assign w_rise  = r_active && (r_div == w_div_rise);
    assign w_last  = (r_bit_cnt == 5'(FRAME_W));
    assign done    = w_fall && w_last;
    assign rx_data = {r_shift[FRAME_W-2:0], r_smp};
    assign SCLK    = r_div[DIV_W-1];
    assign MOSI    = r_shift[FRAME_W-1];
    assign ss_req  = r_active;

    // Divider free-runs while a frame is active; frame end parks it at the preset so SCLK stays high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div    <= w_div_load;
            r_active <= 1'b0;
        end else if (go) begin
            r_div    <= w_div_load;
            r_active <= 1'b1;
        end else if (done) begin
            r_div    <= w_div_load;
            r_active <= 1'b0;
        end else if (r_active) begin
            r_div    <= r_div + DIV_W'(1);
        end
    end

    // Sample MISO on the rise, shift on the fall; the first fall of a frame has nothing to shift in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_smp     <= 1'b0;
            r_bit_cnt <= '0;
        end else if (go) begin
            r_shift   <= cmd;
            r_bit_cnt <= '0;
        end else begin
            if (w_rise) begin
                r_smp     <= MISO;
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            if (w_fall && (r_bit_cnt != 5'd0)) begin
                r_shift <= {r_shift[FRAME_W-2:0], r_smp};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/a2d_spi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : a2d_spi_bridge
// Brief    : SPI master for the 8-channel 12-bit A2D. A start request runs a
//            channel-select frame, a short SS_n-high gap, then a second frame
//            whose low 12 bits become the result with a sticky complete flag.
// Revision : 1.0 - initial release
// ============================================================================
module a2d_spi_bridge
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV_W = 5,
    parameter int GAP_CLKS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strt_cnv,
    input  logic [CH_W-1:0]  chnnl,
    input  logic             MISO,
    output logic             cnv_cmplt,
    output logic [RES_W-1:0] res,
    output logic             SS_n,
    output logic             SCLK,
    output logic             MOSI
);

    localparam int c_GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    state_t             r_state;
    logic [CH_W-1:0]    r_chnnl;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_cnv_cmplt;
    logic [RES_W-1:0]   r_res;

    logic               w_accept;
    logic               w_gap_end;
    logic               w_go;
    logic               w_done;
    logic               w_ss_req;
    logic [FRAME_W-1:0] w_cmd;
    logic [FRAME_W-1:0] w_rx_data;
    logic               w_unused_rx_hi;

    assign w_accept  = (r_state == c_ST_IDLE) && strt_cnv;
    assign w_gap_end = (r_gap_cnt == c_GAP_W'(GAP_CLKS - 1));
    assign w_go      = w_accept || ((r_state == c_ST_GAP) && w_gap_end);
    // The accepting clk uses the live channel; frame 2 reuses the latched one
    assign w_cmd     = build_cmd(w_accept ? chnnl : r_chnnl);

    // Upper nibble of the conversion frame carries no data
    assign w_unused_rx_hi = ^w_rx_data[FRAME_W-1:RES_W];

    spi_frame16 #(
        .DIV_W   (SCLK_DIV_W)
    ) u_frame (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (w_go),
        .cmd     (w_cmd),
        .MISO    (MISO),
        .done    (w_done),
        .rx_data (w_rx_data),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .ss_req  (w_ss_req)
    );

    assign SS_n      = ~w_ss_req;
    assign cnv_cmplt = r_cnv_cmplt;
    assign res       = r_res;

    // Sequence select frame, gap, conversion frame; post the result as frame 2 ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_chnnl     <= '0;
            r_gap_cnt   <= '0;
            r_cnv_cmplt <= 1'b0;
            r_res       <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (strt_cnv) begin
                        r_chnnl     <= chnnl;
                        r_cnv_cmplt <= 1'b0;
                        r_state     <= c_ST_FRM1;
                    end
                end
                c_ST_FRM1: begin
                    if (w_done) begin
                        r_gap_cnt <= '0;
                        r_state   <= c_ST_GAP;
                    end
                end
                c_ST_GAP: begin
                    if (w_gap_end) begin
                        r_state <= c_ST_FRM2;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                    end
                end
                c_ST_FRM2: begin
                    if (w_done) begin
                        r_res       <= w_rx_data[RES_W-1:0];
                        r_cnv_cmplt <= 1'b1;
                        r_state     <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_a2d_spi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_a2d_spi_bridge
// Brief    : Scoreboard bench for a2d_spi_bridge with an A2D slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_a2d_spi_bridge;

    localparam int GAP       = 2;
    localparam int PERIOD    = 32;
    // Divider preset 23 reaches its wrap after 9 counts
    localparam int FRONT     = 9;
    localparam int BACK      = 16;
    // Front porch, 15 full periods to the 16th fall, half period to the 16th rise, back porch
    localparam int FRAME_LOW = FRONT + 15 * PERIOD + PERIOD / 2 + BACK;
    localparam int LATENCY   = 2 * FRAME_LOW + GAP;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        strt_cnv = 1'b0;
    logic [2:0]  chnnl    = 3'd0;
    logic        MISO     = 1'b0;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] cmd_q[$];
    logic [15:0] miso_q[$];
    logic [11:0] res_q[$];
    int          n_exp_cmplt = 0;
    int          n_cmplt     = 0;
    int          sclk_bad    = 0;

    a2d_spi_bridge #(
        .SCLK_DIV_W (5),
        .GAP_CLKS   (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .MISO      (MISO),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: command is channel*2048, result is frame-2 word mod 4096
    task automatic push_conv(input logic [2:0] ch, input logic [15:0] w1, input logic [15:0] w2);
        logic [15:0] cmd;
        cmd = 16'(ch) * 16'd2048;
        cmd_q.push_back(cmd);
        cmd_q.push_back(cmd);
        miso_q.push_back(w1);
        miso_q.push_back(w2);
        res_q.push_back(12'(w2 % 16'd4096));
        n_exp_cmplt++;
    endtask

    task automatic start(input logic [2:0] ch);
        chnnl    = ch;
        strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
    endtask

    task automatic wait_level(input logic val, input string name);
        int n = 0;
        while (cnv_cmplt !== val && n < LATENCY + 64) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, cnv_cmplt}, {31'd0, val});
    endtask

    // Slave model and monitor: everything sampled mid-cycle on the falling clk
    int          cyc = 0;
    logic        p_ss = 1'b1, p_sclk = 1'b1, p_cmplt = 1'b0;
    int          frm_start = 0, last_fall = 0, nfall = 0, first_fall = 0, bad_per = 0;
    int          ss_rise = 0, conv_start = 0, frame_idx = 0, bitidx = 0;
    logic        in_frame = 1'b0;
    logic [15:0] cur_cmd = '0, cur_miso = '0, got_cmd = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                in_frame  = 1'b0;
                frame_idx = 0;
                MISO      = 1'b0;
            end else begin
                if (p_ss && !SS_n) begin
                    in_frame  = 1'b1;
                    frm_start = cyc;
                    nfall     = 0;
                    bad_per   = 0;
                    got_cmd   = '0;
                    bitidx    = 15;
                    if (frame_idx == 0) conv_start = cyc;
                    else check("gap_clks", cyc - ss_rise, GAP);
                    if (cmd_q.size() == 0 || miso_q.size() == 0) begin
                        check("frame_expected", 0, 1);
                        cur_cmd  = '0;
                        cur_miso = '0;
                    end else begin
                        cur_cmd  = cmd_q.pop_front();
                        cur_miso = miso_q.pop_front();
                    end
                end
                if (in_frame && !SS_n) begin
                    if (p_sclk && !SCLK) begin
                        nfall++;
                        if (nfall == 1) first_fall = cyc - frm_start;
                        else if (cyc - last_fall != PERIOD) bad_per++;
                        last_fall = cyc;
                        if (bitidx >= 0) begin
                            MISO = cur_miso[bitidx];
                            bitidx--;
                        end
                    end
                    if (!p_sclk && SCLK) got_cmd = {got_cmd[14:0], MOSI};
                end
                if (SS_n && !SCLK) sclk_bad++;
                if (in_frame && !p_ss && SS_n) begin
                    check("mosi_cmd", got_cmd, cur_cmd);
                    check("sclk_falls", nfall, 16);
                    check("first_fall_clks", first_fall, FRONT);
                    check("sclk_period_errs", bad_per, 0);
                    check("ss_low_clks", cyc - frm_start, FRAME_LOW);
                    in_frame  = 1'b0;
                    ss_rise   = cyc;
                    frame_idx = 1 - frame_idx;
                end
                if (!p_cmplt && cnv_cmplt) begin
                    n_cmplt++;
                    check("latency_clks", cyc - conv_start, LATENCY);
                    if (res_q.size() == 0) check("unexpected_cmplt", 1, 0);
                    else check("res", res, res_q.pop_front());
                end
            end
            p_ss    = SS_n;
            p_sclk  = SCLK;
            p_cmplt = cnv_cmplt;
        end
    end

    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ss_n", SS_n, 1);
        check("rst_sclk", SCLK, 1);
        check("rst_mosi", MOSI, 0);
        check("rst_cnv_cmplt", cnv_cmplt, 0);
        check("rst_res", res, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Channel 3, conversion word 0x0A5C; result must stay posted while idle
        push_conv(3'd3, 16'($urandom), 16'h0A5C);
        start(3'd3);
        wait_level(1'b1, "cmplt_ch3");
        repeat (50) @(negedge clk);
        check("cmplt_sticky", cnv_cmplt, 1);
        check("res_hold", res, 12'hA5C);

        // Channel 7: only the second frame's data is captured
        push_conv(3'd7, 16'hFFFF, 16'h0001);
        start(3'd7);
        wait_level(1'b1, "cmplt_ch7");
        repeat (5) @(negedge clk);

        // Start request and channel change mid-conversion are ignored
        push_conv(3'd3, 16'($urandom), 16'h0123);
        start(3'd3);
        repeat (100) @(negedge clk);
        chnnl    = 3'd5;
        strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        chnnl    = 3'($urandom);
        wait_level(1'b1, "cmplt_ignored_strt");
        repeat (5) @(negedge clk);

        // Reset asserted during bit 7 of the conversion frame
        push_conv(3'd2, 16'($urandom), 16'($urandom));
        start(3'd2);
        repeat (FRAME_LOW + GAP + FRONT + 6 * PERIOD + 4) @(negedge clk);
        check("ss_low_before_reset", SS_n, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ss_n", SS_n, 1);
        check("abort_sclk", SCLK, 1);
        check("abort_cnv_cmplt", cnv_cmplt, 0);
        check("abort_res", res, 0);
        void'(res_q.pop_back());
        n_exp_cmplt--;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_conv(3'd5, 16'($urandom), 16'($urandom));
        start(3'd5);
        wait_level(1'b1, "cmplt_after_reset");
        repeat (5) @(negedge clk);

        // Start held high: back-to-back conversions on channels 0, 4, 6
        push_conv(3'd0, 16'($urandom), 16'($urandom));
        push_conv(3'd4, 16'($urandom), 16'($urandom));
        push_conv(3'd6, 16'($urandom), 16'($urandom));
        chnnl    = 3'd0;
        strt_cnv = 1'b1;
        @(negedge clk);
        wait_level(1'b1, "cmplt_held_0");
        chnnl = 3'd4;
        wait_level(1'b0, "cmplt_clear_4");
        wait_level(1'b1, "cmplt_held_4");
        chnnl = 3'd6;
        wait_level(1'b0, "cmplt_clear_6");
        wait_level(1'b1, "cmplt_held_6");
        strt_cnv = 1'b0;
        repeat (10) @(negedge clk);

        // Random channels and data with random idle spacing
        for (int i = 0; i < 4; i++) begin
            logic [2:0] ch;
            ch = 3'($urandom_range(0, 7));
            push_conv(ch, 16'($urandom), 16'($urandom));
            start(ch);
            chnnl = 3'($urandom);
            wait_level(1'b1, "cmplt_random");
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("cmplt_count", n_cmplt, n_exp_cmplt);
        check("sclk_low_while_ss_high", sclk_bad, 0);
        check("cmd_left", cmd_q.size(), 0);
        check("res_left", res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
